// File: rtl/arp_cache_pkg.sv
// ---------------------------------------------------------------------------
// arp_cache_pkg
// Shared widths and helpers for the ARP cache query arbiter.
//   IP_W   : IPv4 address width
//   MAC_W  : Ethernet MAC width
//   STAT_W : width of the optional statistics counters
//   clog2  : ceiling log2, usable in constant expressions
// ---------------------------------------------------------------------------
package arp_cache_pkg;

  localparam int IP_W   = 32;
  localparam int MAC_W  = 48;
  localparam int STAT_W = 32;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/arp_arb_tag_fifo.sv
// ---------------------------------------------------------------------------
// arp_arb_tag_fifo
// In-order FIFO of requester IDs, one entry per outstanding cache query.
// Full/empty come from the registered occupancy count, so they are stable
// for the whole cycle and do not depend on this cycle's push/pop.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write push_data_i (ignored while full)
//   push_data_i  : requester ID to store
//   pop_i        : drop the head entry (ignored while empty)
//   head_o       : ID at the read pointer
//   full_o       : count == DEPTH
//   empty_o      : count == 0
// ---------------------------------------------------------------------------
module arp_arb_tag_fifo
  import arp_cache_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/arp_cache_query_arb.sv
// ---------------------------------------------------------------------------
// arp_cache_query_arb
// Shares one ARP cache query channel among PORTS requesters. Requests are
// granted round-robin with no added latency; granted IDs are queued in an
// in-order tag FIFO so each cache response is steered back to its issuer.
// Responses arriving with nothing outstanding are accepted and dropped, and
// latch the sticky orphan_response flag.
//
// Optional build macro: ARP_CACHE_ARB_STATS_EN adds stat_clear and three
// saturating counters (stat_queries, stat_hits, stat_misses).
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   s_query_request_*        : per-requester request (valid/ready, packed ip)
//   s_query_response_*       : per-requester response (valid/ready, error, mac)
//   m_query_request_*        : request to the cache
//   m_query_response_*       : response from the cache
//   orphan_response          : sticky, response seen with no query outstanding
// ---------------------------------------------------------------------------
module arp_cache_query_arb
  import arp_cache_pkg::*;
#(
  parameter int PORTS     = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PORTS-1:0]       s_query_request_valid,
  output logic [PORTS-1:0]       s_query_request_ready,
  input  logic [PORTS*IP_W-1:0]  s_query_request_ip,
  output logic [PORTS-1:0]       s_query_response_valid,
  input  logic [PORTS-1:0]       s_query_response_ready,
  output logic [PORTS-1:0]       s_query_response_error,
  output logic [PORTS*MAC_W-1:0] s_query_response_mac,
  output logic                   m_query_request_valid,
  input  logic                   m_query_request_ready,
  output logic [IP_W-1:0]        m_query_request_ip,
  input  logic                   m_query_response_valid,
  output logic                   m_query_response_ready,
  input  logic                   m_query_response_error,
  input  logic [MAC_W-1:0]       m_query_response_mac,
  output logic                   orphan_response
`ifdef ARP_CACHE_ARB_STATS_EN
  ,
  input  logic                   stat_clear,
  output logic [STAT_W-1:0]      stat_queries,
  output logic [STAT_W-1:0]      stat_hits,
  output logic [STAT_W-1:0]      stat_misses
`endif
);

  localparam int ID_W = clog2(PORTS);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            orphan_q, orphan_d;
  logic [ID_W-1:0] grant;
  logic            any_valid;
  logic            tag_full, tag_empty;
  logic [ID_W-1:0] tag_head;
  logic            req_fire, resp_fire, tag_pop;

  // ---------------- round-robin grant ----------------
  // Scan rr_ptr, rr_ptr+1, ... mod PORTS; first valid requester wins.
  always_comb begin
    int  cand;
    logic found;
    grant = rr_ptr_q;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < PORTS; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= PORTS) cand = cand - PORTS;
      if (!found && s_query_request_valid[cand]) begin
        found = 1'b1;
        grant = ID_W'(cand);
      end
    end
  end

  assign any_valid = |s_query_request_valid;

  // Outputs are gated by rst_n so every valid/ready reads 0 during reset,
  // including the combinational paths from inputs.
  assign m_query_request_valid = rst_n && any_valid && !tag_full;
  assign m_query_request_ip    = s_query_request_ip[grant*IP_W +: IP_W];
  assign req_fire              = m_query_request_valid && m_query_request_ready;

  // ---------------- response routing ----------------
  // With nothing outstanding the response is swallowed (ready=1).
  assign m_query_response_ready = rst_n && (tag_empty ? 1'b1 : s_query_response_ready[tag_head]);
  assign resp_fire = m_query_response_valid && m_query_response_ready;
  assign tag_pop   = resp_fire && !tag_empty;

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_lane
      assign s_query_request_ready[gi] = rst_n && any_valid && (grant == ID_W'(gi))
                                         && m_query_request_ready && !tag_full;
      assign s_query_response_valid[gi] = rst_n && !tag_empty && m_query_response_valid
                                          && (tag_head == ID_W'(gi));
      assign s_query_response_error[gi] = m_query_response_error;
      assign s_query_response_mac[gi*MAC_W +: MAC_W] = m_query_response_mac;
    end
  endgenerate

  arp_arb_tag_fifo #(
    .W     (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (req_fire),
    .push_data_i (grant),
    .pop_i       (tag_pop),
    .head_o      (tag_head),
    .full_o      (tag_full),
    .empty_o     (tag_empty)
  );

  // ---------------- state ----------------
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    orphan_d = orphan_q;
    if (req_fire) rr_ptr_d = (grant == ID_W'(PORTS - 1)) ? '0 : grant + ID_W'(1);
    if (resp_fire && tag_empty) orphan_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      orphan_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      orphan_q <= orphan_d;
    end
  end

  assign orphan_response = orphan_q;

`ifdef ARP_CACHE_ARB_STATS_EN
  // ---------------- statistics ----------------
  // Hits/misses count every accepted cache response, orphans included.
  logic [STAT_W-1:0] queries_q, queries_d;
  logic [STAT_W-1:0] hits_q, hits_d;
  logic [STAT_W-1:0] misses_q, misses_d;

  always_comb begin
    queries_d = queries_q;
    hits_d    = hits_q;
    misses_d  = misses_q;
    if (req_fire && (queries_q != '1)) queries_d = queries_q + STAT_W'(1);
    if (resp_fire && !m_query_response_error && (hits_q != '1)) hits_d = hits_q + STAT_W'(1);
    if (resp_fire && m_query_response_error && (misses_q != '1)) misses_d = misses_q + STAT_W'(1);
    if (stat_clear) begin
      queries_d = '0;
      hits_d    = '0;
      misses_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      queries_q <= '0;
      hits_q    <= '0;
      misses_q  <= '0;
    end else begin
      queries_q <= queries_d;
      hits_q    <= hits_d;
      misses_q  <= misses_d;
    end
  end

  assign stat_queries = queries_q;
  assign stat_hits    = hits_q;
  assign stat_misses  = misses_q;
`endif

endmodule

// File: tb/tb_arp_cache_query_arb.sv
// ---------------------------------------------------------------------------
// tb_arp_cache_query_arb
// Bench for the ARP cache query arbiter (PORTS=4, TAG_DEPTH=4). A small cache
// model answers ip -> mac {02, 00000000, ip[7:0]}, miss when ip[31:24]==0x0A.
// Expected responses are queued when a request is granted and compared when
// the arbiter delivers a response.
// ---------------------------------------------------------------------------
module tb_arp_cache_query_arb;

  localparam int P = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [P-1:0]    s_query_request_valid = '0;
  logic [P-1:0]    s_query_request_ready;
  logic [P*32-1:0] s_query_request_ip = '0;
  logic [P-1:0]    s_query_response_valid;
  logic [P-1:0]    s_query_response_ready = '0;
  logic [P-1:0]    s_query_response_error;
  logic [P*48-1:0] s_query_response_mac;
  logic          m_query_request_valid;
  logic          m_query_request_ready = 1'b0;
  logic [31:0]   m_query_request_ip;
  logic          m_query_response_valid = 1'b0;
  logic          m_query_response_ready;
  logic          m_query_response_error = 1'b0;
  logic [47:0]   m_query_response_mac = '0;
  logic          orphan_response;
`ifdef ARP_CACHE_ARB_STATS_EN
  logic          stat_clear = 1'b0;
  logic [31:0]   stat_queries, stat_hits, stat_misses;
`endif

  arp_cache_query_arb #(.PORTS(P), .TAG_DEPTH(4)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .s_query_request_valid  (s_query_request_valid),
    .s_query_request_ready  (s_query_request_ready),
    .s_query_request_ip     (s_query_request_ip),
    .s_query_response_valid (s_query_response_valid),
    .s_query_response_ready (s_query_response_ready),
    .s_query_response_error (s_query_response_error),
    .s_query_response_mac   (s_query_response_mac),
    .m_query_request_valid  (m_query_request_valid),
    .m_query_request_ready  (m_query_request_ready),
    .m_query_request_ip     (m_query_request_ip),
    .m_query_response_valid (m_query_response_valid),
    .m_query_response_ready (m_query_response_ready),
    .m_query_response_error (m_query_response_error),
    .m_query_response_mac   (m_query_response_mac),
    .orphan_response        (orphan_response)
`ifdef ARP_CACHE_ARB_STATS_EN
    ,
    .stat_clear             (stat_clear),
    .stat_queries           (stat_queries),
    .stat_hits              (stat_hits),
    .stat_misses            (stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int lane; logic [47:0] mac; logic err; } exp_t;
  typedef struct { logic [31:0] ip; int due; } pend_t;
  exp_t  sb_q[$];
  pend_t cache_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [47:0] mac_of(input logic [31:0] ip);
    return {8'h02, 32'h0, ip[7:0]};
  endfunction

  function automatic logic err_of(input logic [31:0] ip);
    return ip[31:24] == 8'h0A;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    s_query_request_valid  = '0;
    s_query_response_ready = '0;
    m_query_request_ready  = 1'b0;
    m_query_response_valid = 1'b0;
    m_query_response_error = 1'b0;
    m_query_response_mac   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    sb_q.delete();
    cache_q.delete();
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    s_query_request_valid  = 4'hF;
    s_query_response_ready = 4'hF;
    m_query_request_ready  = 1'b1;
    m_query_response_valid = 1'b1;
    #1;
    n_checks++;
    if ({m_query_request_valid, s_query_request_ready, s_query_response_valid, m_query_response_ready} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req_v=%b req_rdy=%b rsp_v=%b rsp_rdy=%b, want all 0",
               m_query_request_valid, s_query_request_ready, s_query_response_valid, m_query_response_ready);
    end
    m_query_response_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (orphan_response !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_orphan: got %b want 0", orphan_response);
    end
    n_checks++;
    if (s_query_request_ready !== 4'b0001 || m_query_response_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: req_rdy=%b rsp_rdy=%b, want 0001 and 1",
               s_query_request_ready, m_query_response_ready);
    end
    s_query_request_valid = '0;
    m_query_request_ready = 1'b0;
  endtask

  // ------------------------------------------------------------------
  task automatic test_round_robin();
    int exp_grant = 0;
    int grants = 0;
    int resps = 0;
    logic [31:0] lane_ip [P];
    apply_reset();
    lane_ip[0] = 32'hC0A80001; lane_ip[1] = 32'h0;
    lane_ip[2] = 32'h0A000002; lane_ip[3] = 32'h0;
    s_query_request_ip = {lane_ip[3], lane_ip[2], lane_ip[1], lane_ip[0]};
    s_query_request_valid  = 4'b0101;
    s_query_response_ready = 4'hF;
    m_query_request_ready  = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (cache_q.size() > 0 && cache_q[0].due <= cyc) begin
        m_query_response_valid = 1'b1;
        m_query_response_mac   = mac_of(cache_q[0].ip);
        m_query_response_error = err_of(cache_q[0].ip);
      end else begin
        m_query_response_valid = 1'b0;
        m_query_response_mac   = '0;
        m_query_response_error = 1'b0;
      end
      @(negedge clk);
      if (m_query_request_valid && m_query_request_ready) begin
        n_checks++;
        if (s_query_request_ready !== 4'(1 << exp_grant) || m_query_request_ip !== lane_ip[exp_grant]) begin
          n_fail++;
          $display("FAIL rr_grant: ready=%b ip=%h, want ready=%b ip=%h",
                   s_query_request_ready, m_query_request_ip, 4'(1 << exp_grant), lane_ip[exp_grant]);
        end
        cache_q.push_back('{ip: m_query_request_ip, due: cyc + 2});
        sb_q.push_back('{lane: exp_grant, mac: mac_of(lane_ip[exp_grant]), err: err_of(lane_ip[exp_grant])});
        exp_grant = (exp_grant == 0) ? 2 : 0;
        grants++;
      end
      if (m_query_response_valid && m_query_response_ready) begin
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL rr_resp_unexpected: got response valid=%b, want none", s_query_response_valid);
        end else begin
          e = sb_q.pop_front();
          if (s_query_response_valid !== 4'(1 << e.lane) ||
              s_query_response_mac[e.lane*48 +: 48] !== e.mac ||
              s_query_response_error[e.lane] !== e.err) begin
            n_fail++;
            $display("FAIL rr_resp: valid=%b mac=%h err=%b, want valid=%b mac=%h err=%b",
                     s_query_response_valid, s_query_response_mac[e.lane*48 +: 48],
                     s_query_response_error[e.lane], 4'(1 << e.lane), e.mac, e.err);
          end
          $display("rr response lane %0d mac %h err %b", e.lane, e.mac, e.err);
        end
        void'(cache_q.pop_front());
        resps++;
      end
      tick();
    end
    s_query_request_valid = '0;
    m_query_response_valid = 1'b0;
    n_checks++;
    if (grants < 8 || resps < 6) begin
      n_fail++;
      $display("FAIL rr_throughput: grants=%0d responses=%0d, want >=8 and >=6", grants, resps);
    end
  endtask

  // ------------------------------------------------------------------
  task automatic test_tag_full();
    int hs = 0;
    apply_reset();
    for (int k = 0; k < P; k++) s_query_request_ip[k*32 +: 32] = 32'hC0A80010 + k;
    s_query_request_valid  = 4'hF;
    s_query_response_ready = 4'hF;
    m_query_request_ready  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_query_request_valid && m_query_request_ready) begin
        n_checks++;
        if (s_query_request_ready !== 4'(1 << hs)) begin
          n_fail++;
          $display("FAIL full_grant_order: ready=%b, want %b", s_query_request_ready, 4'(1 << hs));
        end
        sb_q.push_back('{lane: hs, mac: mac_of(32'hC0A80010 + hs), err: 1'b0});
        hs++;
      end else begin
        n_checks++;
        if (s_query_request_ready !== 4'b0 || hs != 4) begin
          n_fail++;
          $display("FAIL full_stall: ready=%b after %0d handshakes, want 0000 after 4", s_query_request_ready, hs);
        end
      end
      tick();
    end
    n_checks++;
    if (hs != 4) begin
      n_fail++;
      $display("FAIL full_count: handshakes=%0d, want 4", hs);
    end
    // one response frees one tag
    m_query_response_valid = 1'b1;
    m_query_response_mac   = mac_of(32'hC0A80010);
    m_query_response_error = 1'b0;
    @(negedge clk);
    begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      if (s_query_response_valid !== 4'(1 << e.lane) || m_query_response_ready !== 1'b1 ||
          s_query_response_mac[e.lane*48 +: 48] !== e.mac || s_query_request_ready !== 4'b0) begin
        n_fail++;
        $display("FAIL full_resp: valid=%b rdy=%b mac=%h req_rdy=%b, want %b 1 %h 0000",
                 s_query_response_valid, m_query_response_ready,
                 s_query_response_mac[e.lane*48 +: 48], s_query_request_ready, 4'(1 << e.lane), e.mac);
      end
    end
    tick();
    m_query_response_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_query_request_ready !== 4'b0001 || m_query_request_ip !== 32'hC0A80010) begin
      n_fail++;
      $display("FAIL full_regrant: ready=%b ip=%h, want 0001 c0a80010", s_query_request_ready, m_query_request_ip);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (s_query_request_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL full_single_regrant: ready=%b, want 0000", s_query_request_ready);
    end
    s_query_request_valid = '0;
    tick();
  endtask

  // ------------------------------------------------------------------
  task automatic test_response_backpressure();
    logic [3:0] exp_rdy [2];
    exp_t e;
    apply_reset();
    exp_rdy[0] = 4'b0010;
    exp_rdy[1] = 4'b1000;
    s_query_request_ip[1*32 +: 32] = 32'hC0A80021;
    s_query_request_ip[3*32 +: 32] = 32'h0A000023;
    s_query_request_valid  = 4'b1010;
    s_query_response_ready = 4'b0101;
    m_query_request_ready  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (s_query_request_ready !== exp_rdy[c]) begin
        n_fail++;
        $display("FAIL bp_grant: ready=%b, want %b", s_query_request_ready, exp_rdy[c]);
      end
      if (c == 0) sb_q.push_back('{lane: 1, mac: mac_of(32'hC0A80021), err: 1'b0});
      else        sb_q.push_back('{lane: 3, mac: mac_of(32'h0A000023), err: 1'b1});
      tick();
    end
    s_query_request_valid  = '0;
    m_query_response_valid = 1'b1;
    m_query_response_mac   = mac_of(32'hC0A80021);
    m_query_response_error = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (s_query_response_valid !== 4'b0010 || m_query_response_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall: valid=%b rdy=%b, want 0010 0", s_query_response_valid, m_query_response_ready);
      end
      tick();
    end
    s_query_response_ready = 4'hF;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (s_query_response_valid !== 4'(1 << e.lane) || m_query_response_ready !== 1'b1 ||
          s_query_response_mac[e.lane*48 +: 48] !== e.mac || s_query_response_error[e.lane] !== e.err) begin
        n_fail++;
        $display("FAIL bp_resp: valid=%b rdy=%b mac=%h err=%b, want %b 1 %h %b",
                 s_query_response_valid, m_query_response_ready,
                 s_query_response_mac[e.lane*48 +: 48], s_query_response_error[e.lane],
                 4'(1 << e.lane), e.mac, e.err);
      end
      $display("bp response lane %0d mac %h err %b", e.lane, e.mac, e.err);
      tick();
      m_query_response_mac   = mac_of(32'h0A000023);
      m_query_response_error = 1'b1;
    end
    m_query_response_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_query_response_valid !== 4'b0 || m_query_response_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drained: valid=%b rdy=%b, want 0000 1", s_query_response_valid, m_query_response_ready);
    end
    tick();
  endtask

  // ------------------------------------------------------------------
  task automatic test_orphan();
    apply_reset();
    n_checks++;
    if (orphan_response !== 1'b0) begin
      n_fail++;
      $display("FAIL orphan_init: got %b want 0", orphan_response);
    end
    m_query_response_valid = 1'b1;
    m_query_response_error = 1'b1;
    m_query_response_mac   = 48'h0200000000FF;
    @(negedge clk);
    n_checks++;
    if (m_query_response_ready !== 1'b1 || s_query_response_valid !== 4'b0) begin
      n_fail++;
      $display("FAIL orphan_accept: rdy=%b valid=%b, want 1 0000", m_query_response_ready, s_query_response_valid);
    end
    tick();
    m_query_response_valid = 1'b0;
    m_query_response_error = 1'b0;
    n_checks++;
    if (orphan_response !== 1'b1) begin
      n_fail++;
      $display("FAIL orphan_set: got %b want 1", orphan_response);
    end
    repeat (5) tick();
    n_checks++;
    if (orphan_response !== 1'b1) begin
      n_fail++;
      $display("FAIL orphan_sticky: got %b want 1", orphan_response);
    end
    apply_reset();
    n_checks++;
    if (orphan_response !== 1'b0) begin
      n_fail++;
      $display("FAIL orphan_clear: got %b want 0", orphan_response);
    end
  endtask

  // ------------------------------------------------------------------
  task automatic test_async_reset();
    int hs = 0;
    apply_reset();
    s_query_request_valid  = 4'hF;
    s_query_response_ready = 4'hF;
    m_query_request_ready  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (m_query_request_valid) hs++;
      tick();
    end
    n_checks++;
    if (hs != 3) begin
      n_fail++;
      $display("FAIL areset_setup: handshakes=%0d, want 3", hs);
    end
    m_query_response_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_query_request_valid, s_query_request_ready, s_query_response_valid, m_query_response_ready} !== 10'b0) begin
      n_fail++;
      $display("FAIL areset_outputs: req_v=%b req_rdy=%b rsp_v=%b rsp_rdy=%b, want all 0",
               m_query_request_valid, s_query_request_ready, s_query_response_valid, m_query_response_ready);
    end
    m_query_response_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (s_query_request_ready !== 4'b0001 || m_query_request_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_first_grant: ready=%b valid=%b, want 0001 1", s_query_request_ready, m_query_request_valid);
    end
    s_query_request_valid = '0;
    tick();
  endtask

`ifdef ARP_CACHE_ARB_STATS_EN
  // ------------------------------------------------------------------
  task automatic test_stats();
    logic [31:0] ip;
    apply_reset();
    s_query_response_ready = 4'hF;
    m_query_request_ready  = 1'b1;
    for (int q = 0; q < 5; q++) begin
      ip = (q < 3) ? (32'hC0A80040 + q) : (32'h0A000040 + q);
      s_query_request_ip[31:0] = ip;
      s_query_request_valid = 4'b0001;
      tick();
      s_query_request_valid  = '0;
      m_query_response_valid = 1'b1;
      m_query_response_mac   = mac_of(ip);
      m_query_response_error = err_of(ip);
      tick();
      m_query_response_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (stat_queries !== 32'd5 || stat_hits !== 32'd3 || stat_misses !== 32'd2) begin
      n_fail++;
      $display("FAIL stats_count: q/h/m=%0d/%0d/%0d, want 5/3/2", stat_queries, stat_hits, stat_misses);
    end
    tick();
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stat_queries !== 32'd0 || stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_clear: q/h/m=%0d/%0d/%0d, want 0/0/0", stat_queries, stat_hits, stat_misses);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_tag_full();
    test_response_backpressure();
    test_orphan();
    test_async_reset();
`ifdef ARP_CACHE_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
